// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ---- uart_rx_cfg : oversampled UART receiver, runtime parity/stop config, one-word holding register.
// ---- Optional break detection with UART_RX_BREAK_DETECT_EN.  Rev 1.0
module uart_rx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int OSR       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_os,
  input  logic                 rxd,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                 break_det
`endif
);

  localparam int CW = $clog2(OSR);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] C_S0   = CW'(OSR/2 - 2);
  localparam logic [CW-1:0] C_S1   = CW'(OSR/2 - 1);
  localparam logic [CW-1:0] C_DEC  = CW'(OSR/2);
  localparam logic [CW-1:0] C_WRAP = CW'(OSR - 1);
  localparam logic [BW-1:0] C_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t                 state;
  logic                   sync1, sync2, line_prev;
  logic [1:0]             fill;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic [1:0]             mode;
  logic                   two_stop, s0, s1, par_bit, stop_bad, all_zero;
  logic                   start_edge, par_en, bit_val, decide, wrap, done;
  logic                   frame_bad, par_bad, is_break;

  // line_prev only reports a real high after the synchronizer has refilled from the pin,
  // so a line held low through reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      fill      <= 2'b00;
      line_prev <= 1'b0;
    end else begin
      sync1     <= rxd;
      sync2     <= sync1;
      fill      <= {fill[0], 1'b1};
      line_prev <= sync2 & fill[1];
    end
  end

  always_comb begin
    start_edge = (state == IDLE) && line_prev && !sync2;
    par_en     = (mode == 2'b01) || (mode == 2'b10);
    bit_val    = (s0 & s1) | (s0 & sync2) | (s1 & sync2);
    decide     = tick_os && (cnt == C_DEC);
    wrap       = tick_os && (cnt == C_WRAP);
    done       = decide && (((state == STOP1) && !two_stop) || (state == STOP2));
    frame_bad  = stop_bad | ~bit_val;
    par_bad    = par_en && ((^shreg ^ par_bit) != mode[1]);
  end

`ifdef UART_RX_BREAK_DETECT_EN
  assign is_break = all_zero & ~bit_val;
`else
  assign is_break = 1'b0;
`endif

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      mode     <= 2'b00;
      two_stop <= 1'b0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      par_bit  <= 1'b0;
      stop_bad <= 1'b0;
      all_zero <= 1'b0;
    end else if (start_edge) begin
      state    <= START;
      cnt      <= '0;
      bit_idx  <= '0;
      mode     <= parity_mode;
      two_stop <= stop2;
      stop_bad <= 1'b0;
      all_zero <= 1'b1;
    end else if (tick_os && (state != IDLE)) begin
      cnt <= (cnt == C_WRAP) ? '0 : cnt + 1'b1;
      if (cnt == C_S0) s0 <= sync2;
      if (cnt == C_S1) s1 <= sync2;
      if (decide && (state != START)) all_zero <= all_zero & ~bit_val;
      case (state)
        START: begin
          if ((cnt == C_S1) && sync2) state <= IDLE;
          else if (wrap)              state <= DATA;
        end
        DATA: begin
          if (decide) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (wrap) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == C_LAST) state <= par_en ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (decide) par_bit <= bit_val;
          if (wrap)   state   <= STOP1;
        end
        STOP1: begin
          if (decide) begin
            stop_bad <= stop_bad | ~bit_val;
            if (!two_stop) state <= IDLE;
          end else if (wrap) begin
            state <= STOP2;
          end
        end
        STOP2: begin
          if (decide) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done && !is_break) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= par_bad;
          frame_err  <= frame_bad;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) break_det <= 1'b0;
    else     break_det <= done && is_break;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// tb_uart_rx_cfg: scoreboard bench driving an 8-bit and a 7-bit receiver, both at OSR=16.
module tb_uart_rx_cfg;
  localparam int BT = 64;  // clocks per bit: 16 ticks, one tick every 4 clocks

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic rxd8 = 1'b1, rxd7 = 1'b1, rdy8 = 1'b1, rdy7 = 1'b1, s2_8 = 1'b0, s2_7 = 1'b0;
  logic [1:0] pm8 = 2'b00, pm7 = 2'b00;
  logic [7:0] d8;
  logic [6:0] d7;
  logic v8, v7, pe8, pe7, fe8, fe7, ov8, ov7, bz8, bz7;
`ifdef UART_RX_BREAK_DETECT_EN
  logic bk8, bk7;
`endif

  int checks = 0, errors = 0, ov_cnt8 = 0, bk_cnt8 = 0;

  typedef struct packed {logic [8:0] data; logic pe; logic fe;} exp_t;
  exp_t q8[$], q7[$];
  exp_t e8, e7;

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  end

  uart_rx_cfg #(.DATA_BITS(8), .OSR(16)) u8 (
    .clk(clk), .rst(rst), .tick_os(tick), .rxd(rxd8), .parity_mode(pm8), .stop2(s2_8),
    .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8), .parity_err(pe8), .frame_err(fe8),
    .overrun(ov8), .rx_busy(bz8)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(bk8)
`endif
  );

  uart_rx_cfg #(.DATA_BITS(7), .OSR(16)) u7 (
    .clk(clk), .rst(rst), .tick_os(tick), .rxd(rxd7), .parity_mode(pm7), .stop2(s2_7),
    .rx_data(d7), .rx_valid(v7), .rx_ready(rdy7), .parity_err(pe7), .frame_err(fe7),
    .overrun(ov7), .rx_busy(bz7)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(bk7)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe);
    mk = {d, pe, fe};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 8) rxd8 = v;
    else            rxd7 = v;
  endtask

  // par < 0 means no parity bit on the line; stop_len is the length of the final stop bit
  task automatic send(input int which, input int nbits, input logic [8:0] data, input int par,
                      input int nstop, input logic st1, input logic st2, input int stop_len);
    drive(which, 1'b0);
    wait_clks(BT);
    for (int i = 0; i < nbits; i++) begin
      drive(which, data[i]);
      wait_clks(BT);
    end
    if (par >= 0) begin
      drive(which, par[0]);
      wait_clks(BT);
    end
    drive(which, st1);
    wait_clks((nstop == 2) ? BT : stop_len);
    if (nstop == 2) begin
      drive(which, st2);
      wait_clks(stop_len);
    end
    drive(which, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst && ov8) ov_cnt8++;
`ifdef UART_RX_BREAK_DETECT_EN
    if (!rst && bk8) bk_cnt8++;
`endif
  end

  always @(negedge clk) begin
    if (!rst && v8 && rdy8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word8_unexpected got %0h expected none", d8);
      end else begin
        e8 = q8.pop_front();
        check("word8_data", {24'd0, d8}, {23'd0, e8.data});
        check("word8_parity_err", {31'd0, pe8}, {31'd0, e8.pe});
        check("word8_frame_err", {31'd0, fe8}, {31'd0, e8.fe});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && v7 && rdy7) begin
      if (q7.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word7_unexpected got %0h expected none", d7);
      end else begin
        e7 = q7.pop_front();
        check("word7_data", {25'd0, d7}, {23'd0, e7.data});
        check("word7_parity_err", {31'd0, pe7}, {31'd0, e7.pe});
        check("word7_frame_err", {31'd0, fe7}, {31'd0, e7.fe});
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    wait_clks(5);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid8", {31'd0, v8}, 0);
    check("reset_data8", {24'd0, d8}, 0);
    check("reset_busy8", {31'd0, bz8}, 0);
    check("reset_errs8", {30'd0, pe8, fe8}, 0);
    check("reset_overrun8", {31'd0, ov8}, 0);
    check("reset_valid7", {31'd0, v7}, 0);
    wait_clks(BT);

    // 8-bit, no parity, one stop
    q8.push_back(mk(9'h0A5, 1'b0, 1'b0));
    send(8, 8, 9'h0A5, -1, 1, 1'b1, 1'b1, BT);
    wait_clks(BT);

    // odd parity, good and bad parity bit (0x3C has four ones)
    pm8 = 2'b10;
    q8.push_back(mk(9'h03C, 1'b0, 1'b0));
    send(8, 8, 9'h03C, 1, 1, 1'b1, 1'b1, BT);
    wait_clks(BT);
    q8.push_back(mk(9'h03C, 1'b1, 1'b0));
    send(8, 8, 9'h03C, 0, 1, 1'b1, 1'b1, BT);
    wait_clks(BT);

    // mode 11 behaves as no parity
    pm8 = 2'b11;
    q8.push_back(mk(9'h001, 1'b0, 1'b0));
    send(8, 8, 9'h001, -1, 1, 1'b1, 1'b1, BT);
    wait_clks(BT);

    // even parity, single stop low
    pm8 = 2'b01;
    q8.push_back(mk(9'h05A, 1'b0, 1'b1));
    send(8, 8, 9'h05A, 0, 1, 1'b0, 1'b1, BT);
    wait_clks(2 * BT);

    // next start edge arrives three quarters into the stop bit
    pm8 = 2'b00;
    q8.push_back(mk(9'h081, 1'b0, 1'b0));
    q8.push_back(mk(9'h07E, 1'b0, 1'b0));
    send(8, 8, 9'h081, -1, 1, 1'b1, 1'b1, 48);
    send(8, 8, 9'h07E, -1, 1, 1'b1, 1'b1, BT);
    wait_clks(BT);

    // 7-bit, even parity, two stops; 0x35 has four ones so parity bit 1 is wrong
    pm7 = 2'b01;
    s2_7 = 1'b1;
    q7.push_back(mk(9'h035, 1'b1, 1'b0));
    send(7, 7, 9'h035, 1, 2, 1'b1, 1'b1, BT);
    wait_clks(BT);
    q7.push_back(mk(9'h035, 1'b1, 1'b1));
    send(7, 7, 9'h035, 1, 2, 1'b1, 1'b0, BT);
    wait_clks(2 * BT);
    q7.push_back(mk(9'h035, 1'b0, 1'b0));
    send(7, 7, 9'h035, 0, 2, 1'b1, 1'b1, BT);
    wait_clks(BT);

    // 4-tick glitch on the idle line
    drive(8, 1'b0);
    wait_clks(16);
    drive(8, 1'b1);
    wait_clks(4);
    check("glitch_busy_high", {31'd0, bz8}, 1);
    wait_clks(BT);
    check("glitch_busy_low", {31'd0, bz8}, 0);
    check("glitch_no_valid", {31'd0, v8}, 0);

    // overrun: consumer stalled across two frames
    rdy8 = 1'b0;
    ov_cnt8 = 0;
    q8.push_back(mk(9'h011, 1'b0, 1'b0));
    send(8, 8, 9'h011, -1, 1, 1'b1, 1'b1, BT);
    wait_clks(BT);
    send(8, 8, 9'h022, -1, 1, 1'b1, 1'b1, BT);
    wait_clks(BT);
    check("overrun_hold_data", {24'd0, d8}, 32'h11);
    check("overrun_hold_valid", {31'd0, v8}, 1);
    check("overrun_pulses", ov_cnt8, 1);
    rdy8 = 1'b1;
    wait_clks(3);
    check("overrun_valid_cleared", {31'd0, v8}, 0);
    wait_clks(BT);

    // reset in the middle of data bit 3 of 0xFF
    drive(8, 1'b0);
    wait_clks(BT);
    drive(8, 1'b1);
    wait_clks(3 * BT + BT / 2);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(7 * BT);
    check("abort_no_valid", {31'd0, v8}, 0);
    check("abort_idle", {31'd0, bz8}, 0);
    q8.push_back(mk(9'h05A, 1'b0, 1'b0));
    send(8, 8, 9'h05A, -1, 1, 1'b1, 1'b1, BT);
    wait_clks(BT);

    // line held low for 12 bit times
    bk_cnt8 = 0;
`ifndef UART_RX_BREAK_DETECT_EN
    q8.push_back(mk(9'h000, 1'b0, 1'b1));
`endif
    drive(8, 1'b0);
    wait_clks(12 * BT);
    drive(8, 1'b1);
    wait_clks(2 * BT);
`ifdef UART_RX_BREAK_DETECT_EN
    check("break_pulses", bk_cnt8, 1);
    check("break_no_valid", {31'd0, v8}, 0);
`endif

    for (int i = 0; i < 4000 && (q8.size() != 0 || q7.size() != 0); i++) @(posedge clk);
    check("scoreboard8_drained", q8.size(), 0);
    check("scoreboard7_drained", q7.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OSR, default 16, oversample ticks per bit; even, legal range 8..32.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port tick_os  input  1  one-clk oversample strobe at baud*OSR.
REQ-006 Port rxd  input  1  asynchronous serial line, idle high.
REQ-007 Port parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 Port stop2  input  1  1 = two stop bits checked, 0 = one.
REQ-009 Port rx_data  output  DATA_BITS  received word, LSB first on line.
REQ-010 Port rx_valid  output  1  holding register full.
REQ-011 Port rx_ready  input  1  consumer accepts word when rx_valid&&rx_ready.
REQ-012 Port parity_err  output  1  parity mismatch flag, qualified by rx_valid.
REQ-013 Port frame_err  output  1  any checked stop bit low, qualified by rx_valid.
REQ-014 Port overrun  output  1  one-clk pulse when a completed frame is dropped.
REQ-015 Port rx_busy  output  1  high from start detect until return to IDLE.

Function
REQ-016 rxd SHALL pass a 2-FF synchronizer (reset value 1) before any use; start detect SHALL be a 1->0 transition of the synchronized line while in IDLE.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2; parity_mode and stop2 SHALL be captured at start detect and held for the frame.
REQ-018 Tick counter SHALL clear at start detect and count tick_os 0..OSR-1 per bit, wrapping to 0 at bit boundary.
REQ-019 START: at count OSR/2-1 synchronized rxd SHALL be low, else return to IDLE with no output and no flag; on wrap enter DATA.
REQ-020 DATA/PARITY/STOP bits SHALL be decided by majority of samples at counts OSR/2-2, OSR/2-1, OSR/2.
REQ-021 Data SHALL be shifted LSB first: first data bit received lands in rx_data[0].
REQ-022 After DATA_BITS bits: enter PARITY if mode even/odd, else STOP1; PARITY -> STOP1; STOP1 -> STOP2 if stop2, else complete.
REQ-023 Parity check: even expects XOR(data,parity)=0, odd expects 1.
REQ-024 Frame completes at the decision tick of the last stop bit; the FSM SHALL return to IDLE that cycle so a start edge during the remaining half stop bit is accepted.
REQ-025 On completion with holding register empty, or full and consumed in the same cycle, rx_data/parity_err/frame_err SHALL load and rx_valid SHALL be 1 the next cycle.
REQ-026 On completion with holding register full and not consumed, existing contents SHALL be kept and overrun SHALL pulse one clk.
REQ-027 Handshake: rx_valid&&rx_ready with no completing frame SHALL clear rx_valid next cycle; rx_data SHALL be stable while rx_valid&&!rx_ready.
REQ-028 tick_os low SHALL freeze the counter and FSM, except start detect.

Reset
REQ-029 rst SHALL force IDLE, counter 0, synchronizer to 1, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, rx_busy=0, break_det=0.
REQ-030 rst asserted mid-frame SHALL abandon the frame with no output; reception SHALL restart only on a fresh 1->0 edge after rst deasserts.

Configuration
REQ-031 Macro UART_RX_BREAK_DETECT_EN SHALL add output port break_det (1 bit).
REQ-032 With the macro: a frame whose data, parity and all stop bits decide 0 SHALL NOT load the holding register, SHALL pulse break_det one clk, and SHALL wait in IDLE until synchronized rxd is high before re-arming start detect.
REQ-033 Without the macro: port absent; an all-zero frame SHALL be delivered as data 0 with frame_err=1.

Verification
REQ-034 DATA_BITS=8, OSR=16, mode none, 1 stop, send 0xA5 -> rx_valid with rx_data=0xA5, parity_err=0, frame_err=0.
REQ-035 DATA_BITS=7, mode even, stop2=1, send 0x35 with wrong parity bit -> rx_data=0x35, parity_err=1; same frame with second stop low -> frame_err=1.
REQ-036 Low glitch of 4 ticks on idle line -> no rx_valid, rx_busy returns to 0.
REQ-037 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once; rx_ready then 1 -> rx_valid clears.
REQ-038 rst in DATA bit 3 of 0xFF -> no rx_valid; next frame 0x5A received correctly.
REQ-039 With UART_RX_BREAK_DETECT_EN, hold rxd low 12 bit times -> break_det pulses once, rx_valid stays 0.
